// File: rtl/answer_controller.sv
// answer_controller: quiz-round buzzer FSM with countdown, winner lock and per-player saturating scores
module answer_controller #(
  parameter int NUM_PLAYERS = 4,
  parameter int SCORE_W = 8,
  parameter int INIT_SCORE = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           endset,
  input  logic [7:0]                     maxtime,
  input  logic [3:0]                     maxuser,
  input  logic [3:0]                     scoreadd,
  input  logic [3:0]                     scoresubtract,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         buzz,
  input  logic                           tick,
  input  logic                           judge_right,
  input  logic                           judge_wrong,
  output logic                           ready,
  output logic [3:0]                     winner,
  output logic [7:0]                     countdown,
  output logic                           timeout,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores
);
  typedef enum logic [1:0] {IDLE, READY, ANSWER, LOCKED} state_t;
  state_t r_state, w_next;
  logic [7:0] r_maxtime, r_countdown;
  logic [3:0] r_maxuser, r_add, r_sub, r_winner, w_first;
  logic [SCORE_W-1:0] r_score [NUM_PLAYERS];
  logic [SCORE_W-1:0] w_cur, w_new;
  logic [SCORE_W:0] w_sum, w_diff;
  logic w_hit, w_latch, w_start, w_judge;
  always_comb begin
    w_hit = 1'b0;
    w_first = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--)
      if (buzz[i] && i < int'(r_maxuser)) begin
        w_hit = 1'b1;
        w_first = 4'(i + 1);
      end
  end
  always_comb begin
    w_latch = endset && (r_state == IDLE || (r_state == READY && !start));
    w_start = r_state == READY && start;
    w_judge = r_state == LOCKED && (judge_right || judge_wrong);
  end
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = endset ? READY : IDLE;
      READY:   w_next = start ? ANSWER : READY;
      ANSWER:  w_next = w_hit ? LOCKED : (r_countdown == '0 ? READY : ANSWER);
      LOCKED:  w_next = (judge_right || judge_wrong) ? READY : LOCKED;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    ready = r_state == READY;
    timeout = r_state == ANSWER && !w_hit && r_countdown == '0;
    winner = r_winner;
    countdown = r_countdown;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_maxtime <= '0;
      r_maxuser <= '0;
      r_add <= '0;
      r_sub <= '0;
      r_winner <= '0;
      r_countdown <= '0;
    end else begin
      if (w_latch) begin
        r_maxtime <= maxtime;
        r_maxuser <= maxuser;
        r_add <= scoreadd;
        r_sub <= scoresubtract;
      end
      if (w_start) begin
        r_winner <= '0;
        r_countdown <= r_maxtime;
      end
      if (r_state == ANSWER && w_hit)
        r_winner <= w_first;
      else if (r_state == ANSWER && tick && r_countdown != '0)
        r_countdown <= r_countdown - 8'd1;
    end
  end
  always_comb begin
    w_cur = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (r_winner == 4'(i + 1)) w_cur = r_score[i];
    w_sum = {1'b0, w_cur} + (SCORE_W+1)'(r_add);
    w_diff = {1'b0, w_cur} - (SCORE_W+1)'(r_sub);
    w_new = judge_right ? (w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0])
                        : (w_diff[SCORE_W] ? '0 : w_diff[SCORE_W-1:0]);
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (rst || w_latch) r_score[i] <= SCORE_W'(INIT_SCORE);
      else if (w_judge && r_winner == 4'(i + 1)) r_score[i] <= w_new;
  for (genvar p = 0; p < NUM_PLAYERS; p++)
    assign scores[p*SCORE_W +: SCORE_W] = r_score[p];
endmodule

// File: tb/tb_answer_controller.sv
// tb_answer_controller: directed self-checking bench for answer_controller
module tb_answer_controller;
  logic clk = 0, rst = 0, endset = 0, start = 0, tick = 0, judge_right = 0, judge_wrong = 0;
  logic [7:0] maxtime = 0;
  logic [3:0] maxuser = 0, scoreadd = 0, scoresubtract = 0;
  logic [3:0] buzz = 0;
  logic ready, timeout;
  logic [3:0] winner;
  logic [7:0] countdown;
  logic [31:0] scores;
  int checks = 0, errors = 0;
  answer_controller dut (
    .clk(clk), .rst(rst), .endset(endset), .maxtime(maxtime), .maxuser(maxuser),
    .scoreadd(scoreadd), .scoresubtract(scoresubtract), .start(start), .buzz(buzz),
    .tick(tick), .judge_right(judge_right), .judge_wrong(judge_wrong), .ready(ready),
    .winner(winner), .countdown(countdown), .timeout(timeout), .scores(scores)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    cyc();
    cyc();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0d exp 0", ready); end
    checks++; if (winner !== 4'd0) begin errors++; $display("FAIL reset_winner got %0d exp 0", winner); end
    checks++; if (countdown !== 8'd0) begin errors++; $display("FAIL reset_countdown got %0d exp 0", countdown); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0d exp 0", timeout); end
    checks++; if (scores !== 32'h0a0a0a0a) begin errors++; $display("FAIL reset_scores got %h exp 0a0a0a0a", scores); end
    rst = 0;
    cyc();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL idle_wait_ready got %0d exp 0", ready); end
    maxtime = 5; maxuser = 2; scoreadd = 3; scoresubtract = 2; endset = 1;
    cyc();
    endset = 0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL config_ready got %0d exp 1", ready); end
    checks++; if (scores !== 32'h0a0a0a0a) begin errors++; $display("FAIL config_scores got %h exp 0a0a0a0a", scores); end
  endtask
  task automatic test_buzz_right();
    start = 1;
    cyc();
    start = 0;
    checks++; if (countdown !== 8'd5) begin errors++; $display("FAIL start_countdown got %0d exp 5", countdown); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL answer_ready got %0d exp 0", ready); end
    buzz = 4'b0110;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL buzz_timeout got %0d exp 0", timeout); end
    cyc();
    buzz = 0;
    checks++; if (winner !== 4'd2) begin errors++; $display("FAIL buzz_winner got %0d exp 2", winner); end
    checks++; if (countdown !== 8'd5) begin errors++; $display("FAIL locked_countdown got %0d exp 5", countdown); end
    start = 1; endset = 1;
    cyc();
    start = 0; endset = 0;
    checks++; if (winner !== 4'd2) begin errors++; $display("FAIL locked_ignore_start got %0d exp 2", winner); end
    judge_right = 1;
    cyc();
    judge_right = 0;
    checks++; if (scores !== 32'h0a0a0d0a) begin errors++; $display("FAIL right_score got %h exp 0a0a0d0a", scores); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL right_ready got %0d exp 1", ready); end
    checks++; if (winner !== 4'd2) begin errors++; $display("FAIL hold_winner got %0d exp 2", winner); end
  endtask
  task automatic test_timeout();
    int pulses;
    pulses = 0;
    buzz = 4'b0100;
    start = 1;
    cyc();
    start = 0;
    checks++; if (winner !== 4'd0) begin errors++; $display("FAIL start_clears_winner got %0d exp 0", winner); end
    for (int k = 5; k >= 1; k--) begin
      checks++; if (countdown !== 8'(k)) begin errors++; $display("FAIL tick_countdown got %0d exp %0d", countdown, k); end
      pulses += int'(timeout);
      tick = 1;
      cyc();
      tick = 0;
    end
    checks++; if (countdown !== 8'd0) begin errors++; $display("FAIL countdown_zero got %0d exp 0", countdown); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse got %0d exp 1", timeout); end
    pulses += int'(timeout);
    cyc();
    buzz = 0;
    pulses += int'(timeout);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL timeout_count got %0d exp 1", pulses); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL timeout_ready got %0d exp 1", ready); end
    checks++; if (winner !== 4'd0) begin errors++; $display("FAIL timeout_winner got %0d exp 0", winner); end
    checks++; if (scores !== 32'h0a0a0d0a) begin errors++; $display("FAIL timeout_scores got %h exp 0a0a0d0a", scores); end
  endtask
  task automatic test_buzz_tick();
    start = 1;
    cyc();
    start = 0;
    for (int k = 0; k < 4; k++) begin
      tick = 1;
      cyc();
    end
    buzz = 4'b0011;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL buzz_tick_timeout got %0d exp 0", timeout); end
    cyc();
    tick = 0; buzz = 0;
    checks++; if (winner !== 4'd1) begin errors++; $display("FAIL buzz_tick_winner got %0d exp 1", winner); end
    checks++; if (countdown !== 8'd1) begin errors++; $display("FAIL buzz_tick_frozen got %0d exp 1", countdown); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL locked_timeout got %0d exp 0", timeout); end
    for (int r = 1; r <= 6; r++) begin
      if (r > 1) begin
        start = 1;
        cyc();
        start = 0; buzz = 4'b0001;
        cyc();
        buzz = 0;
      end
      judge_wrong = 1;
      cyc();
      judge_wrong = 0;
      checks++;
      if (scores[7:0] !== 8'((10 - 2*r) < 0 ? 0 : 10 - 2*r)) begin
        errors++; $display("FAIL wrong_floor round %0d got %0d exp %0d", r, scores[7:0], (10 - 2*r) < 0 ? 0 : 10 - 2*r);
      end
    end
    start = 1;
    cyc();
    start = 0; buzz = 4'b0001;
    cyc();
    buzz = 0; judge_right = 1; judge_wrong = 1;
    cyc();
    judge_right = 0; judge_wrong = 0;
    checks++; if (scores[7:0] !== 8'd3) begin errors++; $display("FAIL both_judges got %0d exp 3", scores[7:0]); end
  endtask
  task automatic test_maxuser_zero();
    maxtime = 0; maxuser = 0; endset = 1;
    cyc();
    endset = 0;
    checks++; if (scores !== 32'h0a0a0a0a) begin errors++; $display("FAIL relatch_scores got %h exp 0a0a0a0a", scores); end
    start = 1; endset = 1; maxtime = 9;
    cyc();
    start = 0; endset = 0; buzz = 4'b1111;
    checks++; if (countdown !== 8'd0) begin errors++; $display("FAIL start_over_endset got %0d exp 0", countdown); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL zero_time_timeout got %0d exp 1", timeout); end
    cyc();
    buzz = 0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL zero_user_ready got %0d exp 1", ready); end
    checks++; if (winner !== 4'd0) begin errors++; $display("FAIL zero_user_winner got %0d exp 0", winner); end
  endtask
  task automatic test_saturate();
    maxtime = 5; maxuser = 4; scoreadd = 15; endset = 1;
    cyc();
    endset = 0;
    for (int k = 1; k <= 17; k++) begin
      start = 1;
      cyc();
      start = 0; buzz = 4'b1000;
      cyc();
      buzz = 0; judge_right = 1;
      cyc();
      judge_right = 0;
      checks++;
      if (scores[31:24] !== 8'((10 + 15*k) > 255 ? 255 : 10 + 15*k)) begin
        errors++; $display("FAIL saturate round %0d got %0d exp %0d", k, scores[31:24], (10 + 15*k) > 255 ? 255 : 10 + 15*k);
      end
    end
    checks++; if (scores[23:0] !== 24'h0a0a0a) begin errors++; $display("FAIL saturate_others got %h exp 0a0a0a", scores[23:0]); end
  endtask
  task automatic test_rst_mid();
    start = 1;
    cyc();
    start = 0; buzz = 4'b0001;
    cyc();
    buzz = 0;
    checks++; if (winner !== 4'd1) begin errors++; $display("FAIL pre_rst_winner got %0d exp 1", winner); end
    judge_right = 1; rst = 1;
    cyc();
    judge_right = 0; rst = 0;
    checks++; if (scores !== 32'h0a0a0a0a) begin errors++; $display("FAIL rst_mid_scores got %h exp 0a0a0a0a", scores); end
    checks++; if (winner !== 4'd0) begin errors++; $display("FAIL rst_mid_winner got %0d exp 0", winner); end
    checks++; if (countdown !== 8'd0) begin errors++; $display("FAIL rst_mid_countdown got %0d exp 0", countdown); end
    cyc();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got %0d exp 0", ready); end
  endtask
  initial begin
    cyc();
    test_reset();
    test_buzz_right();
    test_timeout();
    test_buzz_tick();
    test_maxuser_zero();
    test_saturate();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
